draw_rect: RTL and testbench



---
 rtl/vga_pkg.sv | 27 ++
 rtl/delay.sv | 28 ++
 rtl/draw_rect.sv | 136 +++++++++++++
 tb/tb_draw_rect.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA sizes, colours and types for the falling-rectangle rendering path.
package vga_pkg;

   localparam int HOR_PIXELS  = 800;
   localparam int VER_PIXELS  = 600;
   localparam int RECT_WIDTH  = 48;
   localparam int RECT_HEIGHT = 64;

   localparam logic [11:0] RECT_COLOUR = 12'hf_0_0;
   localparam logic [11:0] STOP_COLOUR = 12'h0_f_0;

   // Capture FSM: positions are latched once, on entry to vertical blank.
   typedef enum logic {
      ACTIVE = 1'b0,
      VBLANK = 1'b1
   } rect_state_t;

   typedef struct packed {
      logic [10:0] vcount;
      logic        vsync;
      logic        vblnk;
      logic [10:0] hcount;
      logic        hsync;
      logic        hblnk;
   } vga_timing_t;

endpackage

// File: rtl/delay.sv
// Fixed-depth shift register used to align the VGA timing bus with the
// overlaid pixel colour.
module delay #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_pipe [DEPTH];

   // NOTE: every stage is reset so downstream sees all-zero timing right after
   // rst; a plain data pipeline would normally skip this reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/draw_rect.sv
// Overlays a solid rectangle on the VGA stream; the position is latched at
// vblank start so a frame never tears, and frame_tick marks that instant.
module draw_rect #(
   parameter int          RECT_W      = vga_pkg::RECT_WIDTH,
   parameter int          RECT_H      = vga_pkg::RECT_HEIGHT,
   parameter logic [11:0] COLOUR      = vga_pkg::RECT_COLOUR,
   parameter logic [11:0] STOP_COLOUR = vga_pkg::STOP_COLOUR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] xpos,
   input  logic [11:0] ypos,
   input  logic        stop,
   input  logic [10:0] vcount_in,
   input  logic        vsync_in,
   input  logic        vblnk_in,
   input  logic [10:0] hcount_in,
   input  logic        hsync_in,
   input  logic        hblnk_in,
   input  logic [11:0] rgb_in,
   output logic [10:0] vcount_out,
   output logic        vsync_out,
   output logic        vblnk_out,
   output logic [10:0] hcount_out,
   output logic        hsync_out,
   output logic        hblnk_out,
   output logic [11:0] rgb_out,
   output logic        frame_tick
);

   import vga_pkg::*;

   rect_state_t r_state, w_state_nxt;
   logic        r_vblnk_prev;
   logic        w_capture;

   logic [11:0] r_xpos_l, r_ypos_l;
   logic        r_stop_l, r_valid, r_frame_tick;

   logic        r_hit_d;
   logic [11:0] r_rgb_d1, r_rgb_out;
   logic        w_hit;
   logic [12:0] w_hc, w_vc, w_x_lo, w_x_hi, w_y_lo, w_y_hi;

   vga_timing_t w_timing_in, w_timing_out;

   // vblnk_prev resets high so releasing rst inside vblank is not an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ACTIVE;
         r_vblnk_prev <= 1'b1;
      end else begin
         r_state      <= w_state_nxt;
         r_vblnk_prev <= vblnk_in;
      end
   end

   // NOTE: combinational blocks assign a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ACTIVE:  if (vblnk_in && !r_vblnk_prev) w_state_nxt = VBLANK;
         VBLANK:  if (!vblnk_in)                 w_state_nxt = ACTIVE;
         default:                                w_state_nxt = ACTIVE;
      endcase
   end

   always_comb begin
      w_capture = (r_state == ACTIVE) && vblnk_in && !r_vblnk_prev;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_xpos_l     <= '0;
         r_ypos_l     <= '0;
         r_stop_l     <= 1'b0;
         r_valid      <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= w_capture;
         if (w_capture) begin
            r_xpos_l <= xpos;
            r_ypos_l <= ypos;
            r_stop_l <= stop;
            r_valid  <= 1'b1;
         end
      end
   end

   // 13-bit compares keep xpos_l+RECT_W-1 from wrapping back onto column 0.
   assign w_hc   = {2'b00, hcount_in};
   assign w_vc   = {2'b00, vcount_in};
   assign w_x_lo = {1'b0, r_xpos_l};
   assign w_y_lo = {1'b0, r_ypos_l};
   assign w_x_hi = w_x_lo + 13'(RECT_W - 1);
   assign w_y_hi = w_y_lo + 13'(RECT_H - 1);

   assign w_hit = r_valid && !hblnk_in && !vblnk_in
               && (w_hc >= w_x_lo) && (w_hc <= w_x_hi)
               && (w_vc >= w_y_lo) && (w_vc <= w_y_hi);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit_d   <= 1'b0;
         r_rgb_d1  <= '0;
         r_rgb_out <= '0;
      end else begin
         r_hit_d   <= w_hit;
         r_rgb_d1  <= rgb_in;
         r_rgb_out <= r_hit_d ? (r_stop_l ? STOP_COLOUR : COLOUR) : r_rgb_d1;
      end
   end

   assign w_timing_in = '{vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in,
                          hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in};

   delay #(
      .WIDTH ($bits(vga_timing_t)),
      .DEPTH (2)
   ) u_timing_dly (
      .clk    (clk),
      .rst    (rst),
      .i_data (w_timing_in),
      .o_data (w_timing_out)
   );

   assign vcount_out = w_timing_out.vcount;
   assign vsync_out  = w_timing_out.vsync;
   assign vblnk_out  = w_timing_out.vblnk;
   assign hcount_out = w_timing_out.hcount;
   assign hsync_out  = w_timing_out.hsync;
   assign hblnk_out  = w_timing_out.hblnk;
   assign rgb_out    = r_rgb_out;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_draw_rect.sv
// Directed bench for draw_rect: a cycle-by-cycle reference of the 2-clk
// pipeline plus a table of hand-computed pixel colours.
module tb_draw_rect;

   import vga_pkg::*;

   localparam logic [11:0] RED = 12'hf00;
   localparam logic [11:0] GRN = 12'h0f0;
   localparam logic [11:0] TBG = 12'h5a5;

   localparam int HL[9] = '{99, 100, 101, 147, 148, 299, 300, 347, 348};
   localparam int VL[5] = '{199, 200, 201, 263, 264};

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] xpos, ypos;
   logic        stop;
   logic [10:0] vcount_in, hcount_in;
   logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
   logic [11:0] rgb_in;
   logic [10:0] vcount_out, hcount_out;
   logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
   logic [11:0] rgb_out;
   logic        frame_tick;

   always #5 clk = ~clk;

   draw_rect dut (
      .clk        (clk),
      .rst        (rst),
      .xpos       (xpos),
      .ypos       (ypos),
      .stop       (stop),
      .vcount_in  (vcount_in),
      .vsync_in   (vsync_in),
      .vblnk_in   (vblnk_in),
      .hcount_in  (hcount_in),
      .hsync_in   (hsync_in),
      .hblnk_in   (hblnk_in),
      .rgb_in     (rgb_in),
      .vcount_out (vcount_out),
      .vsync_out  (vsync_out),
      .vblnk_out  (vblnk_out),
      .hcount_out (hcount_out),
      .hsync_out  (hsync_out),
      .hblnk_out  (hblnk_out),
      .rgb_out    (rgb_out),
      .frame_tick (frame_tick)
   );

   typedef struct packed {
      logic [10:0] vc;
      logic        vs;
      logic        vb;
      logic [10:0] hc;
      logic        hs;
      logic        hb;
      logic [11:0] rgb;
   } bundle_t;

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
      logic        s;
      logic [10:0] h;
      logic [10:0] v;
      logic        hb;
      logic [11:0] exp;
   } vec_t;

   int errors = 0;
   int checks = 0;
   int tick_cnt = 0;

   // Reference state: what the rectangle latch should hold right now.
   logic    m_valid, m_stop, m_vprev;
   int      m_x, m_y;
   bundle_t prev_exp;
   bit      prev_valid = 1'b0;

   always @(posedge clk) if (frame_tick) tick_cnt++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bundle_t get_out();
      return '{vc: vcount_out, vs: vsync_out, vb: vblnk_out,
               hc: hcount_out, hs: hsync_out, hb: hblnk_out, rgb: rgb_out};
   endfunction

   function automatic logic [11:0] bg(input int h, input int v);
      return {v[3:0], h[7:0]};
   endfunction

   task automatic drive(input int h, input int v, input logic hs, input logic vs,
                        input logic hb, input logic vb, input logic [11:0] rgb);
      hcount_in = 11'(h);
      vcount_in = 11'(v);
      hsync_in  = hs;
      vsync_in  = vs;
      hblnk_in  = hb;
      vblnk_in  = vb;
      rgb_in    = rgb;
   endtask

   // One pixel clock: predict this pixel's output, drive it, and compare the
   // DUT output against the pixel driven one cycle earlier (2 clk latency).
   task automatic cyc(input int h, input int v, input logic hs, input logic vs,
                      input logic hb, input logic vb, input logic [11:0] rgb);
      bundle_t e;
      logic    cap, hit;
      hit = m_valid && !hb && !vb && (h >= m_x) && (h <= m_x + RECT_WIDTH - 1)
            && (v >= m_y) && (v <= m_y + RECT_HEIGHT - 1);
      e = '{vc: 11'(v), vs: vs, vb: vb, hc: 11'(h), hs: hs, hb: hb,
            rgb: hit ? (m_stop ? GRN : RED) : rgb};
      cap = vb && !m_vprev;
      if (cap) begin
         m_x = int'(xpos);
         m_y = int'(ypos);
         m_stop = stop;
         m_valid = 1'b1;
      end
      m_vprev = vb;
      drive(h, v, hs, vs, hb, vb, rgb);
      @(posedge clk);
      #1;
      if (prev_valid) check("pipe", 64'(get_out()), 64'(prev_exp));
      check("frame_tick", 64'(frame_tick), 64'(cap));
      prev_exp   = e;
      prev_valid = 1'b1;
   endtask

   task automatic pulse_reset(input int h, input int v, input logic vb);
      rst = 1'b1;
      drive(h, v, 1'b0, 1'b0, 1'b0, vb, bg(h, v));
      @(posedge clk);
      #1;
      check("reset_out", 64'({get_out(), frame_tick}), 64'(0));
      rst        = 1'b0;
      m_valid    = 1'b0;
      m_stop     = 1'b0;
      m_vprev    = 1'b1;
      prev_exp   = '0;
      prev_valid = 1'b1;
   endtask

   task automatic vblank();
      cyc(0, VER_PIXELS,     1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
      cyc(0, VER_PIXELS + 1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
      cyc(0, VER_PIXELS + 2, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
   endtask

   // Sparse visible frame around the rectangle edges; xpos/stop may change
   // on line chg_line to exercise mid-frame updates.
   task automatic frame_body(input int chg_line, input int new_x, input logic new_stop);
      for (int vi = 0; vi < 5; vi++) begin
         if (VL[vi] == chg_line) begin
            xpos = 12'(new_x);
            stop = new_stop;
         end
         for (int hi = 0; hi < 9; hi++)
            cyc(HL[hi], VL[vi], HL[hi] % 2 == 1, VL[vi] % 2 == 1, 1'b0, 1'b0, bg(HL[hi], VL[vi]));
         cyc(HOR_PIXELS, VL[vi], 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[19];
      int   t0;
      tbl = '{
         '{12'd100,  12'd200,  1'b0, 11'd100, 11'd200, 1'b0, RED},
         '{12'd100,  12'd200,  1'b0, 11'd147, 11'd263, 1'b0, RED},
         '{12'd100,  12'd200,  1'b0, 11'd123, 11'd231, 1'b0, RED},
         '{12'd100,  12'd200,  1'b0, 11'd99,  11'd200, 1'b0, TBG},
         '{12'd100,  12'd200,  1'b0, 11'd148, 11'd263, 1'b0, TBG},
         '{12'd100,  12'd200,  1'b0, 11'd147, 11'd264, 1'b0, TBG},
         '{12'd100,  12'd200,  1'b0, 11'd100, 11'd199, 1'b0, TBG},
         '{12'd100,  12'd200,  1'b0, 11'd100, 11'd200, 1'b1, TBG},
         '{12'd100,  12'd200,  1'b1, 11'd100, 11'd200, 1'b0, GRN},
         '{12'd100,  12'd200,  1'b1, 11'd147, 11'd263, 1'b0, GRN},
         '{12'd4080, 12'd0,    1'b0, 11'd0,   11'd0,   1'b0, TBG},
         '{12'd4080, 12'd0,    1'b0, 11'd15,  11'd63,  1'b0, TBG},
         '{12'd4095, 12'd4095, 1'b0, 11'd0,   11'd0,   1'b0, TBG},
         '{12'd0,    12'd0,    1'b0, 11'd0,   11'd0,   1'b0, RED},
         '{12'd0,    12'd0,    1'b0, 11'd47,  11'd63,  1'b0, RED},
         '{12'd0,    12'd0,    1'b0, 11'd48,  11'd0,   1'b0, TBG},
         '{12'd100,  12'd700,  1'b0, 11'd100, 11'd599, 1'b0, TBG},
         '{12'd300,  12'd200,  1'b0, 11'd300, 11'd200, 1'b0, RED},
         '{12'd300,  12'd200,  1'b0, 11'd299, 11'd200, 1'b0, TBG}
      };

      xpos = '0;
      ypos = '0;
      stop = 1'b0;
      drive(0, VER_PIXELS, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);

      // Reset held and released inside vblank: no capture, no tick.
      pulse_reset(0, VER_PIXELS, 1'b1);
      pulse_reset(0, VER_PIXELS, 1'b1);
      xpos = 12'd100;
      ypos = 12'd200;
      repeat (3) cyc(0, VER_PIXELS, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);

      // Frame 0: nothing latched yet, background everywhere.
      frame_body(-1, 0, 1'b0);
      check("tick_before_first_vblank", 64'(tick_cnt), 64'(0));

      // Capture x=100; move to 300 mid-frame, which must wait for the next vblank.
      vblank();
      frame_body(263, 300, 1'b0);
      t0 = tick_cnt;
      vblank();
      frame_body(264, 300, 1'b1);
      vblank();
      frame_body(201, 300, 1'b0);
      vblank();
      frame_body(-1, 0, 1'b0);
      check("tick_count_3_frames", 64'(tick_cnt - t0), 64'(3));

      // Mid-frame reset at vcount 400 hides the rectangle until the next capture.
      cyc(100, 399, 1'b0, 1'b0, 1'b0, 1'b0, bg(100, 399));
      pulse_reset(100, 400, 1'b0);
      frame_body(-1, 0, 1'b0);
      vblank();
      frame_body(-1, 0, 1'b0);

      for (int i = 0; i < 19; i++) begin
         xpos = tbl[i].x;
         ypos = tbl[i].y;
         stop = tbl[i].s;
         cyc(0, VER_PIXELS, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
         repeat (2) cyc(int'(tbl[i].h), int'(tbl[i].v), 1'b0, 1'b0, tbl[i].hb, 1'b0, TBG);
         check($sformatf("vec%0d", i), 64'(rgb_out), 64'(tbl[i].exp));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
